// File: rtl/debounce_sync.sv
// Synchronize and debounce one asynchronous level; optional abort counter under DEBOUNCE_SYNC_GLITCH_CNT_EN.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges, capture edge counted as the first; no backpressure (free-running level path).
module debounce_sync #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic       i_signal,
    output logic       o_stable,
    output logic       o_busy
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    ,
    output logic [7:0] o_glitch_count
`endif
);

    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_CONFIRM = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   stable_q;
    logic                   busy_q;

    // Pure flop chain: nothing combinational between stages.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_signal};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            stable_q <= RESET_LEVEL;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_STABLE: begin
                    if (s != stable_q) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            stable_q <= s;
                        end else begin
                            state_q <= ST_CONFIRM;
                            cnt_q   <= CW'(1);
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (s != stable_q) begin
                        if (cnt_q == CNT_LAST) begin
                            stable_q <= s;
                            cnt_q    <= '0;
                            state_q  <= ST_STABLE;
                            busy_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        // Input fell back before confirmation: drop the candidate.
                        cnt_q   <= '0;
                        state_q <= ST_STABLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_STABLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_stable = stable_q;
    assign o_busy   = busy_q;

`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    logic       abort;
    logic [7:0] glitch_q;

    assign abort = (state_q == ST_CONFIRM) && (s == stable_q);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            glitch_q <= 8'd0;
        end else if (abort && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign o_glitch_count = glitch_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed scenarios plus random level runs against a run-length reference model.
// Two instances share the input: default build (16 cycles) and the single-cycle configuration.
module tb_debounce_sync;

    localparam int S = 2;
    localparam int D = 16;

    logic i_clk    = 1'b0;
    logic i_arst_n = 1'b1;
    logic i_signal = 1'b0;
    logic stable_a, busy_a, stable_b, busy_b;
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
    logic [7:0] gc_a, gc_b;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 i_clk = ~i_clk;

    debounce_sync #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_LEVEL(1'b0)) u_dut (
        .i_clk          (i_clk),
        .i_arst_n       (i_arst_n),
        .i_signal       (i_signal),
        .o_stable       (stable_a),
        .o_busy         (busy_a)
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
        ,
        .o_glitch_count (gc_a)
`endif
    );

    debounce_sync #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) u_dut1 (
        .i_clk          (i_clk),
        .i_arst_n       (i_arst_n),
        .i_signal       (i_signal),
        .o_stable       (stable_b),
        .o_busy         (busy_b)
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
        ,
        .o_glitch_count (gc_b)
`endif
    );

    // Reference: o_stable flips once the synchronized level has disagreed with it for
    // D consecutive edges; a disagreement run that ends early is one glitch.
    bit m_pipe   [2][S];
    bit m_stable [2];
    int m_run    [2];
    int m_glitch [2];
    int m_d      [2];
    bit ms;

    always @(posedge i_clk or negedge i_arst_n) begin
        for (int m = 0; m < 2; m++) begin
            if (!i_arst_n) begin
                for (int k = 0; k < S; k++) m_pipe[m][k] = 1'b0;
                m_stable[m] = 1'b0;
                m_run[m]    = 0;
                m_glitch[m] = 0;
            end else begin
                ms = m_pipe[m][S-1];
                if (ms != m_stable[m]) begin
                    m_run[m]++;
                    if (m_run[m] == m_d[m]) begin
                        m_stable[m] = ms;
                        m_run[m]    = 0;
                    end
                end else begin
                    if (m_run[m] > 0 && m_glitch[m] < 255) m_glitch[m]++;
                    m_run[m] = 0;
                end
                for (int k = S - 1; k > 0; k--) m_pipe[m][k] = m_pipe[m][k-1];
                m_pipe[m][0] = i_signal;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge i_clk);
        chk("stable_a", 32'(stable_a), 32'(m_stable[0]));
        chk("busy_a",   32'(busy_a),   32'(m_run[0] > 0));
        chk("stable_b", 32'(stable_b), 32'(m_stable[1]));
        chk("busy_b",   32'(busy_b),   32'd0);
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
        chk("glitch_a", 32'(gc_a), 32'(m_glitch[0]));
        chk("glitch_b", 32'(gc_b), 32'(m_glitch[1]));
`endif
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Drive a new held level; capture edge is edge 1, so the change should land on edge S+D.
    task automatic step_to(input bit lvl, input string tag);
        int edges;
        int busy_run;
        edges    = 0;
        busy_run = 0;
        i_signal = lvl;
        while (edges < 100) begin
            cyc();
            edges++;
            if (stable_a == lvl) break;
            busy_run = busy_a ? busy_run + 1 : 0;
        end
        chk({tag, "_latency"}, 32'(edges), 32'(S + D));
        chk({tag, "_busy_run"}, 32'(busy_run), 32'(D - 1));
    endtask

    initial begin
        int hi_cnt;
        int g0;
        bit changed;
        m_d[0] = D;
        m_d[1] = 1;

        // Reset held with a toggling input.
        #1 i_arst_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            i_signal = ~i_signal;
            cyc();
            chk("rst_stable", 32'(stable_a), 32'd0);
            chk("rst_busy",   32'(busy_a),   32'd0);
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
            chk("rst_glitch", 32'(gc_a), 32'd0);
`endif
        end
        i_signal = 1'b0;
        i_arst_n = 1'b1;
        cycn(5);

        // Clean steps up and down.
        step_to(1'b1, "clean_rise");
        cycn(5);
        step_to(1'b0, "clean_fall");
        cycn(5);

        // Bounce every 3 clocks for 40 clocks, then settle high.
        changed = 1'b0;
        for (int i = 0; i < 40; i++) begin
            i_signal = ((i / 3) % 2) == 0;
            cyc();
            if (stable_a != 1'b0) changed = 1'b1;
        end
        chk("bounce_no_change", 32'(changed), 32'd0);
        step_to(1'b1, "bounce_settle");
        cycn(3);
        step_to(1'b0, "bounce_back");
        cycn(5);

        // Near miss: 15-cycle pulse must not pass.
        g0 = m_glitch[0];
        changed = 1'b0;
        i_signal = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (stable_a) changed = 1'b1;
        end
        i_signal = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (stable_a) changed = 1'b1;
        end
        chk("nearmiss_stable", 32'(changed), 32'd0);
        chk("nearmiss_glitch_model", 32'(m_glitch[0] - g0), 32'd1);
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
        chk("nearmiss_glitch", 32'(gc_a), 32'(g0 + 1));
`endif

        // 16-cycle pulse passes and is held high for 16 cycles.
        hi_cnt = 0;
        i_signal = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (stable_a) hi_cnt++;
        end
        i_signal = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (stable_a) hi_cnt++;
        end
        chk("pulse16_high_cycles", 32'(hi_cnt), 32'd16);

        // Reset while confirming drops the candidate.
        i_signal = 1'b1;
        cycn(8);
        chk("midconf_busy", 32'(busy_a), 32'd1);
        i_arst_n = 1'b0;
        i_signal = 1'b0;
        cyc();
        chk("midconf_rst_stable", 32'(stable_a), 32'd0);
        chk("midconf_rst_busy",   32'(busy_a),   32'd0);
        i_arst_n = 1'b1;
        changed = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (stable_a || busy_a) changed = 1'b1;
        end
        chk("midconf_after", 32'(changed), 32'd0);

        // 300 forced aborts saturate the glitch counter.
        for (int n = 0; n < 300; n++) begin
            i_signal = 1'b1;
            cycn(4);
            i_signal = 1'b0;
            cycn(4);
        end
        cycn(4);
        chk("sat_model", 32'(m_glitch[0]), 32'd255);
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
        chk("sat_glitch", 32'(gc_a), 32'd255);
`endif

        // Random level runs of mixed lengths.
        for (int n = 0; n < 150; n++) begin
            i_signal = 1'($urandom_range(0, 1));
            cycn(int'($urandom_range(1, 40)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
